demux_route_sequencer: RTL
==========================

# demux_route_sequencer

Command-driven sequencer that sits directly upstream of the 1:8 demux tree and generates its `in` and `sel` inputs. It accepts routing commands over a valid/ready interface and buffers them in a small FIFO. For each command it steers a pulse train of programmable length to one of the 8 channels, then inserts one guard cycle before the next command. Commands addressed to masked-off channels are dropped and counted.

## Interface
- `CH_W`, 3: channel index width; channel count is 2**CH_W (8).
- `LEN_W`, 4: pulse-length field width.
- `DEPTH`, 4: command FIFO depth; must be a power of 2, ≥ 2.
- `clk` in 1: single clock; all logic is rising-edge.
- `rst` in 1: synchronous, active-high reset.
- `cmd_valid` in 1: a command is presented.
- `cmd_ready` out 1: FIFO can accept a command; equals !full.
- `cmd_ch` in CH_W: target channel.
- `cmd_len` in LEN_W: pulse length in cycles; 0 means no-op.
- `ch_mask` in 2**CH_W: per-channel enable, bit i enables channel i; sampled at pop.
- `demux_in` out 1: registered serial data driven to the demux `in`.
- `demux_sel` out CH_W: registered channel select driven to the demux `sel`.
- `busy` out 1: high while the FSM is in DRIVE or GUARD.
- `done` out 1: one-cycle pulse, high during the GUARD cycle.
- `drop_cnt` out 8: saturating count of commands dropped because of the mask.

## Operation
- Push: a command {ch, len} enters the FIFO on `cmd_valid && cmd_ready`. There is no bypass; every command passes through the FIFO.
- FSM states: IDLE, DRIVE, GUARD. Reset state is IDLE.
- IDLE, FIFO non-empty: pop one entry this cycle, then:
  - len == 0: consume silently. No drive, no `done`, no count. Stay in IDLE.
  - `ch_mask[ch]` == 0: increment `drop_cnt`, saturating at 255. Stay in IDLE.
  - Otherwise: register `demux_sel`=ch, `demux_in`=1, cnt=len. Go to DRIVE.
- IDLE, FIFO empty: `demux_in`=0 and `demux_sel` holds its last value.
- DRIVE: `demux_in`=1 and `demux_sel` is held. Decrement cnt each cycle. When cnt==1, the next state is GUARD with `demux_in`=0.
- GUARD: `demux_in`=0, `demux_sel` held, `done`=1. Next state is IDLE.
- `ch_mask` changes during DRIVE do not affect the command in flight.
- Simultaneous push and pop are allowed in the same cycle; occupancy is unchanged.
- FIFO full: `cmd_ready`=0 and any presented command is not accepted. A pop in that cycle frees a slot only from the next cycle, because `cmd_ready` is registered from occupancy.
- Pointer arithmetic is modulo DEPTH. Occupancy is held in a log2(DEPTH)+1 bit counter.

## Timing
- Reset values: `cmd_ready`=1, `demux_in`=0, `demux_sel`=0, `busy`=0, `done`=0, `drop_cnt`=0. FIFO empty, state IDLE.
- Reset mid-operation: at the next edge all of the above apply. The FIFO contents are discarded and the pulse is truncated.
- Command accepted at edge t into an empty FIFO with the FSM idle:
  - pop at cycle t+1;
  - `demux_in` high for cycles t+2 … t+1+len;
  - GUARD (`done`=1) at cycle t+2+len;
  - IDLE at t+3+len.
- Back-to-back valid commands: period is len+2 cycles (pop cycle plus len drive cycles plus guard). `demux_sel` changes only on a pop cycle edge.
- Dropped or len==0 commands: each takes 1 IDLE cycle.

## Structure
- Package `demux_route_pkg` holds:
  - the state enum {IDLE, DRIVE, GUARD};
  - default constants CH_W=3, LEN_W=4, DEPTH=4;
  - the command struct {ch, len}.
- Sub-module `cmd_fifo`: synchronous FIFO, width CH_W+LEN_W, depth DEPTH. It has push/pop/full/empty ports and contains the FIFO storage, pointers and occupancy counter.
- Top level: FSM, length counter, output registers, drop counter.

## Test plan
- Reset, then single command {ch=5, len=3} with mask=0xFF:
  - `demux_sel`=5 and `demux_in`=1 for exactly 3 cycles starting 2 cycles after acceptance;
  - `done` pulses once on the following cycle;
  - `busy` high for 4 cycles.
- Push 5 commands back-to-back, each len=2, channels 0–4, with the FSM stalled on the first:
  - `cmd_ready` goes low after 4 are buffered;
  - the 5th is accepted only after the first pop;
  - outputs show channels 0..4 in order, 4 cycles apart.
- mask=0xF7 with command {ch=3, len=4}:
  - no `demux_in` pulse and no `done`;
  - `drop_cnt` 0→1.
- Issue 300 masked commands: `drop_cnt` saturates at 255.
- Command {ch=2, len=0}: consumed in 1 cycle, no pulse, `drop_cnt` unchanged.
- `rst` asserted during cycle 2 of a len=8 drive with 2 commands queued:
  - next edge gives `demux_in`=0, `demux_sel`=0, `cmd_ready`=1;
  - no further pulses after reset release.

Source files
------------

// File: rtl/demux_route_sequencer_pkg.sv
// Shared types and default sizing for the demux route sequencer.
package demux_route_pkg;

  localparam int CH_W_DEF  = 3;
  localparam int LEN_W_DEF = 4;
  localparam int DEPTH_DEF = 4;

  typedef enum logic [1:0] {
    st_idle  = 2'd0,
    st_drive = 2'd1,
    st_guard = 2'd2
  } state_t;

  // Routing command as it sits in the FIFO, sized at the default widths.
  typedef struct packed {
    logic [CH_W_DEF-1:0]  ch;
    logic [LEN_W_DEF-1:0] len;
  } cmd_t;

endpackage

// File: rtl/demux_route_sequencer_if.sv
// Command valid/ready channel into the route sequencer.
interface demux_route_sequencer_if #(
  parameter int CH_W  = 3,
  parameter int LEN_W = 4
) ();

  logic             cmd_valid;
  logic             cmd_ready;
  logic [CH_W-1:0]  cmd_ch;
  logic [LEN_W-1:0] cmd_len;

  modport master (
    output cmd_valid,
    output cmd_ch,
    output cmd_len,
    input  cmd_ready
  );

  modport slave (
    input  cmd_valid,
    input  cmd_ch,
    input  cmd_len,
    output cmd_ready
  );

endinterface

// File: rtl/demux_route_sequencer_cmd_fifo.sv
// Synchronous command FIFO; push and pop are ignored when full/empty.
module cmd_fifo #(
  parameter int W     = 7,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] wdata,
  input  logic         pop,
  output logic [W-1:0] rdata,
  output logic         full,
  output logic         empty
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   occ;
  logic          do_push;
  logic          do_pop;

  assign full    = (occ == (AW+1)'(DEPTH));
  assign empty   = (occ == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rd_ptr];

  // Storage write; contents need no reset since occupancy guards reads.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= wdata;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      occ    <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   occ <= occ + (AW+1)'(1);
        2'b01:   occ <= occ - (AW+1)'(1);
        default: occ <= occ;
      endcase
    end
  end

endmodule

// File: rtl/demux_route_sequencer.sv
// Route sequencer: pops commands and drives a pulse train into the demux tree.
//
//   state    | meaning
//   st_idle  | waiting; pops one command per cycle when the FIFO is non-empty
//   st_drive | demux_in high, length counter running down to terminal count
//   st_guard | one dead cycle with demux_in low, done asserted
module demux_route_sequencer
  import demux_route_pkg::*;
#(
  parameter int CH_W  = CH_W_DEF,
  parameter int LEN_W = LEN_W_DEF,
  parameter int DEPTH = DEPTH_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  demux_route_sequencer_if.slave cmd,
  input  logic [2**CH_W-1:0]    ch_mask,
  output logic                  demux_in,
  output logic [CH_W-1:0]       demux_sel,
  output logic                  busy,
  output logic                  done,
  output logic [7:0]            drop_cnt
);

  localparam int W = CH_W + LEN_W;

  state_t           state, state_nxt;
  logic [LEN_W-1:0] cnt, cnt_nxt;
  logic             in_nxt;
  logic [CH_W-1:0]  sel_nxt;
  logic [7:0]       drop_nxt;
  logic             pop;
  logic             full;
  logic             empty;
  logic [W-1:0]     rdata;
  logic [CH_W-1:0]  pop_ch;
  logic [LEN_W-1:0] pop_len;

  cmd_fifo #(
    .W     (W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (cmd.cmd_valid),
    .wdata ({cmd.cmd_ch, cmd.cmd_len}),
    .pop   (pop),
    .rdata (rdata),
    .full  (full),
    .empty (empty)
  );

  // Ready follows registered occupancy, so a pop never frees a slot same-cycle.
  assign cmd.cmd_ready = !full;
  assign pop_ch        = rdata[W-1:LEN_W];
  assign pop_len       = rdata[LEN_W-1:0];
  assign busy          = (state != st_idle);
  assign done          = (state == st_guard);

  // Next-state, counter and output-register decisions.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    in_nxt    = demux_in;
    sel_nxt   = demux_sel;
    drop_nxt  = drop_cnt;
    pop       = 1'b0;
    case (state)
      st_idle: begin
        in_nxt = 1'b0;
        if (!empty) begin
          pop = 1'b1;
          // Zero-length commands are consumed with no side effects.
          if (pop_len != '0) begin
            if (!ch_mask[pop_ch]) begin
              if (drop_cnt != 8'hff) drop_nxt = drop_cnt + 8'd1;
            end else begin
              sel_nxt   = pop_ch;
              in_nxt    = 1'b1;
              cnt_nxt   = pop_len;
              state_nxt = st_drive;
            end
          end
        end
      end
      st_drive: begin
        if (cnt == LEN_W'(1)) begin
          in_nxt    = 1'b0;
          state_nxt = st_guard;
        end else begin
          cnt_nxt = cnt - LEN_W'(1);
        end
      end
      st_guard: begin
        in_nxt    = 1'b0;
        state_nxt = st_idle;
      end
      default: begin
        in_nxt    = 1'b0;
        state_nxt = st_idle;
      end
    endcase
  end

  // State, counter and registered demux outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= st_idle;
      cnt       <= '0;
      demux_in  <= 1'b0;
      demux_sel <= '0;
      drop_cnt  <= '0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      demux_in  <= in_nxt;
      demux_sel <= sel_nxt;
      drop_cnt  <= drop_nxt;
    end
  end

endmodule
